// File: rtl/vector_tester.sv
// Exhaustive 64-vector driver/checker for a six-input gate network.
// Counts mismatches and records the first failing vector index.
module vector_tester #(
    parameter int unsigned SETTLE       = 3,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic [5:0] first_fail
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [5:0] v;
    logic [5:0] stim;
    logic [3:0] cnt;
    logic       exp_y;
    logic       accept;
    logic       sample;
    logic       mismatch;
    logic       last;
    logic       stop_now;

    assign {a, b, c, d, e, f} = stim;
    assign exp_y = ~(~(a & b) & (c & ~b & d) & ~(e | f));

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done & (err_count == 7'd0);

    always_comb begin
        state_nx = state;
        accept   = start && (state != RUN);
        sample   = (state == RUN) && (cnt == 4'd0);
        // 4-state compare so an X/Z response counts as a failure
        mismatch = sample && (y_in !== exp_y);
        last     = sample && (v == 6'd63);
        stop_now = mismatch && STOP_ON_FAIL;
        unique case (state)
            IDLE, DONE: if (start) state_nx = RUN;
            RUN:        if (last || stop_now) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            v          <= 6'd0;
            stim       <= 6'd0;
            cnt        <= 4'd0;
            err_count  <= 7'd0;
            first_fail <= 6'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                v          <= 6'd0;
                stim       <= 6'd0;
                cnt        <= RELOAD;
                err_count  <= 7'd0;
                first_fail <= 6'd0;
            end else if (sample) begin
                if (mismatch) begin
                    if (err_count != 7'd64) err_count <= err_count + 7'd1;
                    if (err_count == 7'd0) first_fail <= v;
                end
                if (last || stop_now) begin
                    stim <= 6'd0;
                    cnt  <= 4'd0;
                end else begin
                    v    <= v + 6'd1;
                    stim <= v + 6'd1;
                    cnt  <= RELOAD;
                end
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vector_tester.sv
// Bench for vector_tester: three instances covering SETTLE=3, stop-on-fail
// and SETTLE=1; table vectors, hand sequences and randomized responses.
module tb_vector_tester;

    logic       clk = 1'b0;
    logic       rst;
    logic       sv   [3];
    logic       yv   [3];
    logic [5:0] st   [3];
    logic       bz   [3];
    logic       dn   [3];
    logic       ps   [3];
    logic [6:0] ec   [3];
    logic [5:0] ff   [3];
    logic       resp [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic a, b, c, d, e, f;
        vector_tester #(
            .SETTLE      ((g == 2) ? 1 : 3),
            .STOP_ON_FAIL(g == 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (sv[g]),
            .y_in      (yv[g]),
            .a         (a),
            .b         (b),
            .c         (c),
            .d         (d),
            .e         (e),
            .f         (f),
            .busy      (bz[g]),
            .done      (dn[g]),
            .pass      (ps[g]),
            .err_count (ec[g]),
            .first_fail(ff[g])
        );
        assign st[g] = {a, b, c, d, e, f};
        assign yv[g] = resp[st[g]];
    end

    // golden network response for vector index k (a = MSB)
    function automatic bit ref_exp(int k);
        bit a, b, c, d, e, f;
        {a, b, c, d, e, f} = 6'(k);
        return ~(~(a & b) & (c & ~b & d) & ~(e | f));
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_resp(int kind);
        for (int k = 0; k < 64; k++)
            case (kind)
                0: resp[k] = ref_exp(k);
                1: resp[k] = 1'b1;
                default: resp[k] = 1'b0;
            endcase
    endtask

    // start pulse (or held start); returns busy cycles
    task automatic run(int i, bit hold, output int cyc);
        @(negedge clk);
        sv[i] = 1'b1;
        @(negedge clk);
        if (!hold) sv[i] = 1'b0;
        cyc = 0;
        while (bz[i] && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int sel;
        int kind;
        int err;
        int first;
        int cyc;
        int pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cyc;
        tbl[0] = '{0, 0,  0,  0, 192, 1};
        tbl[1] = '{0, 1,  2, 12, 192, 0};
        tbl[2] = '{0, 2, 62,  0, 192, 0};
        tbl[3] = '{1, 1,  1, 12,  39, 0};
        tbl[4] = '{2, 0,  0,  0,  64, 1};
        tbl[5] = '{2, 1,  2, 12,  64, 0};

        set_resp(0);
        for (int i = 0; i < 3; i++) sv[i] = 1'b0;
        rst = 1'b1;
        sv[0] = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i), bz[i], 0);
            check($sformatf("rst_done%0d", i), dn[i], 0);
            check($sformatf("rst_err%0d", i), ec[i], 0);
            check($sformatf("rst_stim%0d", i), st[i], 0);
        end
        sv[0] = 1'b0;
        rst = 1'b0;

        for (int t = 0; t < 6; t++) begin
            int s;
            s = tbl[t].sel;
            set_resp(tbl[t].kind);
            run(s, 1'b0, cyc);
            check($sformatf("t%0d_cyc", t), cyc, tbl[t].cyc);
            check($sformatf("t%0d_done", t), dn[s], 1);
            check($sformatf("t%0d_err", t), ec[s], tbl[t].err);
            check($sformatf("t%0d_first", t), ff[s], tbl[t].first);
            check($sformatf("t%0d_pass", t), ps[s], tbl[t].pass);
            check($sformatf("t%0d_stim", t), st[s], 0);
        end

        // reset in mid-run at vector 20
        set_resp(2);
        @(negedge clk);
        sv[0] = 1'b1;
        @(negedge clk);
        sv[0] = 1'b0;
        cyc = 0;
        while (st[0] != 6'd20 && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        check("rstrun_reach20", st[0], 20);
        check("rstrun_err_pre", ec[0], 19);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstrun_busy", bz[0], 0);
        check("rstrun_done", dn[0], 0);
        check("rstrun_err", ec[0], 0);
        check("rstrun_stim", st[0], 0);
        set_resp(0);
        run(0, 1'b0, cyc);
        check("rerun_cyc", cyc, 192);
        check("rerun_pass", ps[0], 1);

        // start held through a whole SETTLE=1 run
        run(2, 1'b1, cyc);
        check("hold_cyc", cyc, 64);
        check("hold_done", dn[2], 1);
        @(negedge clk);
        check("hold_restart_busy", bz[2], 1);
        check("hold_restart_done", dn[2], 0);
        sv[2] = 1'b0;
        cyc = 0;
        while (!dn[2] && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        check("hold_rerun_pass", ps[2], 1);

        // randomized responses against a counting model
        for (int t = 0; t < 12; t++) begin
            int s, nerr, first, ecyc, settle;
            bit stop;
            s = $urandom_range(0, 2);
            settle = (s == 2) ? 1 : 3;
            stop = (s == 1);
            nerr = 0;
            first = 0;
            for (int k = 0; k < 64; k++) begin
                resp[k] = ref_exp(k) ^ ($urandom_range(0, 15) == 0);
                if (resp[k] !== ref_exp(k)) begin
                    if (nerr == 0) first = k;
                    nerr++;
                end
            end
            ecyc = 64 * settle;
            if (stop && nerr > 0) begin
                ecyc = (first + 1) * settle;
                nerr = 1;
            end
            run(s, 1'b0, cyc);
            check($sformatf("r%0d_cyc", t), cyc, ecyc);
            check($sformatf("r%0d_err", t), ec[s], nerr);
            check($sformatf("r%0d_first", t), ff[s], first);
            check($sformatf("r%0d_pass", t), ps[s], nerr == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_tester.md
VECTOR_TESTER -- requirements
Module: vector_tester

Interface
REQ-001 Parameter SETTLE, default 3, clock cycles each vector is held before y_in is sampled; legal range 1..15.
REQ-002 Parameter STOP_ON_FAIL, default 0; 1 ends the run at the first mismatch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin an exhaustive run; level sampled on the rising edge.
REQ-006 y_in  input  1  response of the gate-level unit under test.
REQ-007 a, b, c, d, e, f  output  1 each  stimulus to the unit under test, registered.
REQ-008 busy  output  1  high while a run is in progress.
REQ-009 done  output  1  high after a run completes, until the next accepted start or rst.
REQ-010 pass  output  1  high when done=1 and err_count=0.
REQ-011 err_count  output  7  number of mismatching vectors in the last run, 0..64.
REQ-012 first_fail  output  6  index of the first mismatching vector; valid when err_count!=0.

Function
REQ-013 The vector index v[5:0] SHALL map as a=v[5], b=v[4], c=v[3], d=v[2], e=v[1], f=v[0].
REQ-014 Expected response: exp = ~( ~(a&b) & (c&~b&d) & ~(e|f) ), computed from the registered stimulus.
REQ-015 States: IDLE, RUN, DONE.
- IDLE: a..f=0, busy=0.
- RUN: stimulus = v, busy=1.
- DONE: a..f=0, busy=0, done=1.
REQ-016 Start accept: start=1 in IDLE or DONE at edge E0.
- Enter RUN with v=0.
- Clear err_count, first_fail, and done at E0.
REQ-017 Start=1 in RUN SHALL be ignored.
REQ-018 Vector k (0..63) SHALL be driven from edge E0+k*SETTLE through edge E0+(k+1)*SETTLE.
- y_in is sampled and compared at edge E0+(k+1)*SETTLE.
- The same edge advances v to k+1.
REQ-019 A mismatch SHALL use 4-state inequality, so X or Z on y_in counts as a mismatch.
REQ-020 On each mismatch, err_count SHALL increment by 1; it never exceeds 64 and never wraps.
REQ-021 On the first mismatch of a run, first_fail SHALL load k; later mismatches leave it unchanged.
REQ-022 After vector 63 is sampled (edge E0+64*SETTLE), the block SHALL enter DONE; v does not wrap to 0 within the run.
REQ-023 With STOP_ON_FAIL=1, the first mismatch SHALL move the block to DONE at that sampling edge; no further vectors are driven.
REQ-024 A settle counter of 4 bits SHALL reload to SETTLE-1 on each vector change and count down to 0 at the sampling edge.
REQ-025 pass SHALL be combinationally equal to done & (err_count==0).
REQ-026 Start=1 coincident with the final sampling edge SHALL be ignored; the block enters DONE.

Reset
REQ-027 rst=1 at any edge SHALL force, regardless of other inputs including start:
- state=IDLE, v=0, settle counter=0;
- a..f=0, busy=0, done=0;
- err_count=0, first_fail=0.
REQ-028 Reset during RUN SHALL abort the run with no partial-result retention; the next start begins at vector 0.

Verification
REQ-029 SETTLE=3, y_in driven by the golden gate network, start pulse at E0:
- busy=1 for 192 cycles;
- done=1 after E0+192;
- err_count=0, pass=1.
REQ-030 y_in stuck at 1, SETTLE=3:
- err_count=2, first_fail=12 (vector 6'b001100);
- second failure is vector 44 (6'b101100);
- pass=0.
REQ-031 y_in stuck at 0:
- err_count=62, first_fail=0;
- done after 64*SETTLE cycles.
REQ-032 STOP_ON_FAIL=1, y_in stuck at 1:
- DONE entered at edge E0+13*SETTLE;
- err_count=1, first_fail=12;
- a..f=0 afterwards.
REQ-033 rst=1 for one cycle while v=20:
- next cycle a..f=0, busy=0, done=0, err_count=0.
- A subsequent start re-runs from vector 0 and reproduces REQ-029.
REQ-034 start held high through an entire run (SETTLE=1):
- the run is not restarted mid-run;
- DONE entered at E0+64;
- the next edge with start=1 in DONE restarts the run with done cleared.
